// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, controller
// states, the saturating counter update and the statistics width.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam int STAT_W = 16;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } bp_state_e;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: one asynchronous lookup port and one
// write port that either loads WNT (init walk) or applies a training update.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_load,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] table_q [DEPTH];
    logic [1:0] table_d [DEPTH];

    always_comb begin
        table_d = table_q;
        if (wr_en) begin
            table_d[wr_idx] = wr_load ? CNT_WNT : sat_update(table_q[wr_idx], wr_taken);
        end
    end

    // Contents are made valid by the controller's init walk, not by reset.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    assign rd_cnt = table_q[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch prediction controller: INIT/RUN FSM, table init walk, flush/redirect.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic            if_is_branch,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic            busy,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic            res_taken,
    input  logic            res_pred_taken,
    output logic            flush,
    output logic            redirect_taken
`ifdef BP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
`endif
);

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] walk_q, walk_d;

    logic             tbl_wr_en;
    logic             tbl_wr_load;
    logic [IDX_W-1:0] tbl_wr_idx;
    logic [1:0]       rd_cnt;
    logic             run_ok;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] res_idx;
    logic             unused_pc_bits;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign res_idx = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                              res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

    // Updates arriving while rst is high are dropped.
    always_comb begin
        state_d     = state_q;
        walk_d      = walk_q;
        tbl_wr_en   = 1'b0;
        tbl_wr_load = 1'b0;
        tbl_wr_idx  = walk_q;
        run_ok      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    tbl_wr_en   = 1'b1;
                    tbl_wr_load = 1'b1;
                    walk_d      = walk_q + 1'b1;
                    if (walk_q == {IDX_W{1'b1}}) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    run_ok = 1'b1;
                    if (res_valid) begin
                        tbl_wr_en  = 1'b1;
                        tbl_wr_idx = res_idx;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
        end
    end

    bp_counter_table #(
        .IDX_W(IDX_W)
    ) u_table (
        .clk      (clk),
        .wr_en    (tbl_wr_en),
        .wr_load  (tbl_wr_load),
        .wr_idx   (tbl_wr_idx),
        .wr_taken (res_taken),
        .rd_idx   (if_idx),
        .rd_cnt   (rd_cnt)
    );

    assign busy           = rst | (state_q == ST_INIT);
    assign pred_taken     = run_ok & if_valid & if_is_branch & rd_cnt[1];
    assign flush          = run_ok & res_valid & (res_taken != res_pred_taken);
    assign redirect_taken = flush & res_taken;

`ifdef BP_STATS_EN
    logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (run_ok && res_valid && stat_branches_q != {STAT_W{1'b1}}) begin
            stat_branches_d = stat_branches_q + 1'b1;
        end
        if (flush && stat_mispred_q != {STAT_W{1'b1}}) begin
            stat_mispred_d = stat_mispred_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = rst ? '0 : stat_branches_q;
    assign stat_mispred  = rst ? '0 : stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Testbench for branch_pred_ctrl: directed plan plus random traffic, checked by
// a scoreboard fed from an array-based reference model. Honours BP_STATS_EN.
module tb_branch_pred_ctrl;

    localparam int PC_W    = 32;
    localparam int IDX_W   = 4;
    localparam int ENTRIES = 1 << IDX_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic            if_is_branch;
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic            busy;
    logic            res_valid;
    logic [PC_W-1:0] res_pc;
    logic            res_taken;
    logic            res_pred_taken;
    logic            flush;
    logic            redirect_taken;
`ifdef BP_STATS_EN
    logic [15:0]     stat_branches;
    logic [15:0]     stat_mispred;
`endif

    always #5 clk = ~clk;

    branch_pred_ctrl #(
        .PC_W (PC_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_is_branch  (if_is_branch),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_taken     (res_taken),
        .res_pred_taken(res_pred_taken),
        .flush         (flush),
        .redirect_taken(redirect_taken)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    typedef struct {
        logic pred;
        logic busy;
        logic flush;
        logic redir;
        int   sb;
        int   sm;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: counter values as plain integers 0..3 per table entry.
    int model [ENTRIES];
    int init_left = 0;
    int sb_m = 0;
    int sm_m = 0;
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ifv, input logic ifb, input logic [31:0] ipc,
                                 input logic rv, input logic [31:0] rpc, input logic rt, input logic rpt);
        exp_t e;
        int ii;
        int ri;
        bit running;
        @(negedge clk);
        rst = r; if_valid = ifv; if_is_branch = ifb; if_pc = ipc;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_pred_taken = rpt;
        ii = int'((ipc >> 2) % ENTRIES);
        ri = int'((rpc >> 2) % ENTRIES);
        running = !r && (init_left == 0);
        e.busy  = r || (init_left > 0);
        e.pred  = running && ifv && ifb && (model[ii] >= 2);
        e.flush = running && rv && (rt != rpt);
        e.redir = e.flush && rt;
        e.sb    = r ? 0 : sb_m;
        e.sm    = r ? 0 : sm_m;
        exp_q.push_back(e);
        if (r) begin
            for (int k = 0; k < ENTRIES; k++) model[k] = 1;
            init_left = ENTRIES;
            sb_m = 0;
            sm_m = 0;
        end else if (init_left > 0) begin
            init_left--;
        end else if (rv) begin
            model[ri] = rt ? ((model[ri] == 3) ? 3 : model[ri] + 1) : ((model[ri] == 0) ? 0 : model[ri] - 1);
            if (sb_m < 65535) sb_m++;
            if (rt != rpt && sm_m < 65535) sm_m++;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(1'b0, 1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic pt);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, t, pt);
    endtask

    // Monitor: outputs are combinational, so each cycle's expectation is
    // compared mid-cycle, after the driver has settled the inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pred_taken", {31'b0, pred_taken}, {31'b0, e.pred});
                checkOutput("busy", {31'b0, busy}, {31'b0, e.busy});
                checkOutput("flush", {31'b0, flush}, {31'b0, e.flush});
                checkOutput("redirect_taken", {31'b0, redirect_taken}, {31'b0, e.redir});
`ifdef BP_STATS_EN
                checkOutput("stat_branches", {16'b0, stat_branches}, e.sb);
                checkOutput("stat_mispred", {16'b0, stat_mispred}, e.sm);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_is_branch = 1'b0; if_pc = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_pred_taken = 1'b0;
        for (int k = 0; k < ENTRIES; k++) model[k] = 1;

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (ENTRIES) idle();
        lookup(32'h40);

        resolve(32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        lookup(32'h44);
        resolve(32'h48, 1'b1, 1'b1);

        repeat (5) resolve(32'h80, 1'b1, 1'b1);
        resolve(32'h80, 1'b0, 1'b1);
        lookup(32'h80);
        repeat (2) resolve(32'h80, 1'b0, 1'b0);
        lookup(32'h80);
        repeat (3) resolve(32'h80, 1'b0, 1'b0);
        lookup(32'h80);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0);
        repeat (ENTRIES) applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        lookup(32'h80);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
        lookup(32'h40);

        repeat (500) begin
            applyStimulus(1'($urandom_range(0, 149) == 0), 1'($urandom % 2), 1'($urandom % 2),
                          ($urandom & 32'hFFFF_FF80) | ($urandom_range(0, 31) << 2) | ($urandom % 4),
                          1'($urandom % 2),
                          ($urandom & 32'hFFFF_FF80) | ($urandom_range(0, 31) << 2) | ($urandom % 4),
                          1'($urandom % 2), 1'($urandom % 2));
        end

        repeat (2) @(negedge clk);
        #4;
        if (exp_q.size() != 0) checkOutput("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Branch prediction controller for the pipelined MIPS core. It owns a table of 2-bit saturating counters indexed by branch PC. It supplies a taken/not-taken prediction to IF and trains the table from resolution results in ID. On a misprediction it raises the pipeline flush/redirect request, and after reset it sequences a table-initialisation walk before predictions are trusted.

## Interface
- Parameters:
  - `PC_W`, 32, PC width in bits (byte address).
  - `IDX_W`, 4, table index width; the table has 2^IDX_W entries.
- Ports:
  - `clk` input 1: single clock, rising edge.
  - `rst` input 1: reset, synchronous and active-high.
  - `if_valid` input 1: IF holds a valid instruction.
  - `if_is_branch` input 1: IF instruction is a beq/bne (predecoded).
  - `if_pc` input PC_W: IF instruction address.
  - `pred_taken` output 1: prediction for the IF instruction.
  - `busy` output 1: table initialisation in progress; the pipeline stalls fetch of branches.
  - `res_valid` input 1: a branch resolved this cycle.
  - `res_pc` input PC_W: address of the resolved branch.
  - `res_taken` input 1: actual outcome (equal_or_not for beq).
  - `res_pred_taken` input 1: the prediction that was made for this branch, carried down the pipe.
  - `flush` output 1: mispredict; squash younger instructions.
  - `redirect_taken` output 1: when `flush`=1, 1 = fetch target, 0 = fetch fall-through.
  - `stat_branches` output 16: only with `BP_STATS_EN`.
  - `stat_mispred` output 16: only with `BP_STATS_EN`.

## Operation
- **Index:** `pc[IDX_W+1:2]`, the same for lookup and update.
- **Counter encoding:**
  - 00 = strong not-taken (SNT), 01 = weak not-taken (WNT), 10 = weak taken (WT), 11 = strong taken (ST).
  - Prediction = counter MSB.
- **Update on resolution:**
  - Taken: counter increments, saturating at 11.
  - Not-taken: counter decrements, saturating at 00.
- **FSM states:** INIT and RUN.
  - **INIT:** entered on `rst`. A walk counter runs 0..2^IDX_W-1 and writes WNT to one entry per cycle.
    - `busy`=1 and `pred_taken`=0.
    - `res_valid` is ignored: no update, `flush`=0.
    - INIT goes to RUN after the last entry is written.
  - **RUN:**
    - `pred_taken` = MSB of entry[if index] & `if_valid` & `if_is_branch`.
    - `res_valid` updates entry[res index].
    - `flush` = `res_valid` & (`res_taken` != `res_pred_taken`).
    - `redirect_taken` = `res_taken` while `flush` is high, otherwise 0.
- **Simultaneous lookup and update of the same index:** the prediction uses the pre-update value; there is no bypass.
- **Reset asserted mid-RUN:** returns to INIT, restarts the walk from 0 and zeroes the statistics. Any update in the same cycle is dropped.
- **Outputs during reset:** `pred_taken`=0, `busy`=1, `flush`=0, `redirect_taken`=0, statistics=0.

## Timing
- **Prediction:** combinational from `if_pc` through a table read; zero-cycle latency.
- **Update:** written at the rising edge that samples `res_valid`. It is visible to a lookup in the next cycle.
- **Flush/redirect:** combinational in the resolution cycle. The pipeline registers it and the IF redirect occurs at the next edge.
- **`busy`:** high for exactly 2^IDX_W cycles after the first cycle with `rst`=0. It is high throughout while `rst`=1.

## Configuration
- **`BP_STATS_EN` defined:**
  - `stat_branches` increments on each RUN-state `res_valid`.
  - `stat_mispred` increments on each `flush`.
  - Both are 16-bit, saturate at 0xFFFF and reset to 0.
- **`BP_STATS_EN` undefined:** the counters and both ports are absent. The prediction and flush behaviour is identical.

## Structure
- **Package `bp_pkg`:**
  - Counter encoding constants (SNT/WNT/WT/ST).
  - State typedef (INIT/RUN).
  - Saturating-update function.
  - Stats width constant.
- **Sub-module `bp_counter_table`:** the 2^IDX_W x 2 flop array with one async read port (lookup), one write port and the saturating update logic.
  - `branch_pred_ctrl` holds the FSM, init walk, flush logic and stats.

## Test plan
- **Reset release:** after `rst`=1 then 0, `busy`=1 for 16 cycles then 0. A lookup at `if_pc`=0x40 then gives `pred_taken`=0 (WNT).
- **Training:** `res_valid`, `res_pc`=0x40, `res_taken`=1 once, so the counter goes 01→10. The next cycle's lookup at 0x40 gives `pred_taken`=1. A lookup at 0x44 still gives 0.
- **Mispredict:** `res_valid`=1, `res_taken`=1, `res_pred_taken`=0 gives `flush`=1 and `redirect_taken`=1 in that cycle. The matching case (both 1) gives `flush`=0.
- **Saturation:**
  - Five taken updates on 0x80 then one not-taken: counter 11→10, predicts taken.
  - Two more not-taken: counter 00, predicts not-taken.
  - Further not-taken updates hold at 00.
- **Same-index collision:** a lookup and a taken update on 0x40 in the same cycle from WNT gives `pred_taken`=0 that cycle and 1 the next.
- **INIT interaction and statistics:**
  - `res_valid` with a mismatch during INIT gives `flush`=0 and the table is unchanged.
  - `rst` pulsed mid-RUN gives `busy`=1 again and all entries back to WNT.
  - With `BP_STATS_EN`, 3 resolutions including 1 mispredict give `stat_branches`=3 and `stat_mispred`=1.
